// File: rtl/riscv_cache_flush_sequencer.sv
// riscv_cache_flush_sequencer: walks every set/way, writes dirty lines back via the BIU, then invalidates the cache
// Ports: clk_i/rst_ni clock and async active-low reset; flush_req_i starts a flush from IDLE;
//   busy_o/done_o status; mem_idx_o/fill_way_o/mem_rreq_o/mem_flushing_o drive the tag/data memories;
//   way_dirty_i/evict_tag_i/evict_line_i report the selected way RD_LAT cycles later;
//   biu_req_o/biu_adr_o/biu_d_o/biu_ack_i carry one writeback at a time.
module riscv_cache_flush_sequencer #(
  parameter int XLEN     = 32,
  parameter int WAYS     = 2,
  parameter int IDX_BITS = 2,
  parameter int TAG_BITS = 26,
  parameter int BLK_BITS = 128,
  parameter int RD_LAT   = 2
) (
  input  logic                rst_ni,
  input  logic                clk_i,
  input  logic                flush_req_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [IDX_BITS-1:0] mem_idx_o,
  output logic [WAYS-1:0]     fill_way_o,
  output logic                mem_rreq_o,
  output logic                mem_flushing_o,
  input  logic                way_dirty_i,
  input  logic [TAG_BITS-1:0] evict_tag_i,
  input  logic [BLK_BITS-1:0] evict_line_i,
  output logic                biu_req_o,
  output logic [XLEN-1:0]     biu_adr_o,
  output logic [BLK_BITS-1:0] biu_d_o,
  input  logic                biu_ack_i
);
  localparam int BOFFS = $clog2(BLK_BITS / 8);
  localparam int AW    = TAG_BITS + IDX_BITS + BOFFS;
  localparam int CW    = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  typedef enum logic [2:0] {IDLE, READ, CHECK, WB, NEXT, INVAL, DONE} state_t;
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [IDX_BITS-1:0] idx_q;
  logic [WAYS-1:0]     way_q;
  logic [XLEN-1:0]     adr_q, adr_n;
  logic [BLK_BITS-1:0] line_q;
  logic [AW-1:0]       adr_full;
  logic                last_way, last_set;
  assign adr_full = {evict_tag_i, idx_q, {BOFFS{1'b0}}};
  // line address is truncated (or zero-extended) to the core address width
  if (AW >= XLEN) begin : g_trunc
    assign adr_n = adr_full[XLEN-1:0];
  end else begin : g_ext
    assign adr_n = {{(XLEN-AW){1'b0}}, adr_full};
  end
  assign last_way = way_q[WAYS-1];
  assign last_set = &idx_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = flush_req_i ? READ : IDLE;
      READ:    state_d = cnt_q == '0 ? CHECK : READ;
      CHECK:   state_d = way_dirty_i ? WB : NEXT;
      WB:      state_d = biu_ack_i ? NEXT : WB;
      NEXT:    state_d = last_way && last_set ? INVAL : READ;
      INVAL:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      way_q  <= WAYS'(1);
      adr_q  <= '0;
      line_q <= '0;
    end else begin
      // read latency counter restarts on every entry into READ
      if (state_d == READ && state_q != READ) cnt_q <= CW'(RD_LAT - 1);
      else if (state_q == READ && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      if (state_q == IDLE && flush_req_i) begin
        idx_q <= '0;
        way_q <= WAYS'(1);
      end
      // one-hot rotate; wrapping out of the last way advances the set
      if (state_q == NEXT) begin
        way_q <= (way_q << 1) | WAYS'(last_way);
        idx_q <= idx_q + IDX_BITS'(last_way);
      end
      if (state_q == CHECK && way_dirty_i) begin
        adr_q  <= adr_n;
        line_q <= evict_line_i;
      end
    end
  end
  assign busy_o         = state_q != IDLE;
  assign mem_rreq_o     = state_q != IDLE;
  assign done_o         = state_q == DONE;
  assign mem_flushing_o = state_q == INVAL;
  assign biu_req_o      = state_q == WB;
  assign mem_idx_o      = idx_q;
  assign fill_way_o     = way_q;
  assign biu_adr_o      = adr_q;
  assign biu_d_o        = line_q;
endmodule
